sum_pipe: RTL and testbench

- Parametrised, multi-lane, two-stage registered adder with valid/ready handshake on both sides.
- Generalises the 4-bit operand/sum blocks used in the assignment-semantics exercises to N lanes of WIDTH bits.
- Adds backpressure, a per-lane accumulate mode, an accumulator clear, and an optional saturating result.
- Sits between a stimulus source and a checker/sink; intended as the reusable arithmetic datapath for later basic blocks.

---
 rtl/sum_pipe_pkg.sv | 35 +++
 rtl/sum_pipe_if.sv | 28 ++
 rtl/sum_lane.sv | 64 ++++++
 rtl/sum_pipe.sv | 114 +++++++++++
 tb/tb_sum_pipe.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sum_pipe_pkg.sv
// sum_pipe_pkg: shared types and helpers for the sum_pipe datapath.
//   mode_e     : per-item operation (add / accumulate).
//   lane()     : extracts lane i (w bits wide) from a packed lane vector.
//   sat_trunc(): reduces a widened lane sum to w bits, wrapping or saturating.
// Helpers work on fixed maximum widths (W_MAX per lane, VEC_MAX per vector);
// callers zero-extend arguments and narrow results with size casts.
package sum_pipe_pkg;

  localparam int unsigned W_MAX     = 32;
  localparam int unsigned VEC_MAX   = 1024;
  localparam int unsigned SUM_MAX_W = W_MAX + 2;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_ACC = 1'b1
  } mode_e;

  function automatic logic [W_MAX-1:0] lane(input logic [VEC_MAX-1:0] vec,
                                            input int unsigned      i,
                                            input int unsigned      w);
    logic [VEC_MAX-1:0] sh;
    sh = vec >> (i * w);
    return sh[W_MAX-1:0];
  endfunction

  function automatic logic [W_MAX-1:0] sat_trunc(input logic [SUM_MAX_W-1:0] full_sum,
                                                 input int unsigned        w,
                                                 input bit                 sat);
    logic [SUM_MAX_W-1:0] lim;
    lim = (SUM_MAX_W'(1) << w) - SUM_MAX_W'(1);
    if (sat && (full_sum > lim)) return lim[W_MAX-1:0];
    return full_sum[W_MAX-1:0] & lim[W_MAX-1:0];
  endfunction

endpackage

// File: rtl/sum_pipe_if.sv
// sum_pipe_if: operand/result handshake bundle for sum_pipe.
//   in_valid/in_ready/in_a/in_b/in_mode : operand channel (source -> pipe)
//   out_valid/out_ready/out_sum/out_ovf : result channel  (pipe -> sink)
//   master : stimulus/sink side, slave : the pipe itself.
interface sum_pipe_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LANES = 2
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_a;
  logic [LANES*WIDTH-1:0] in_b;
  logic                   in_mode;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] out_sum;
  logic [LANES-1:0]       out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_mode, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/sum_lane.sv
// sum_lane: stage-2 arithmetic for one lane.
//   clk, rst : clock, synchronous active-high reset
//   load     : an item advances from s1 into s2 this cycle
//   acc_clr  : zero the accumulator at this edge
//   mode     : add or accumulate for the advancing item
//   a, b     : the advancing item's operands for this lane
//   sum, ovf : registered lane result and overflow flag
module sum_lane
  import sum_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter bit          SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             acc_clr,
  input  mode_e            mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  localparam int unsigned FW = WIDTH + 2;

  logic [FW-1:0]    full;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    full  = FW'(a) + FW'(b) + ((mode == MODE_ACC) ? FW'(acc_q) : '0);
    res   = WIDTH'(sat_trunc(SUM_MAX_W'(full), WIDTH, SAT));
    sum_d = sum_q;
    ovf_d = ovf_q;
    acc_d = acc_q;
    if (load) begin
      sum_d = res;
      ovf_d = (full > FW'({WIDTH{1'b1}}));
      if (mode == MODE_ACC) acc_d = res;
    end
    // The advancing item already used the pre-clear acc in 'full';
    // the clear takes priority only for the stored value.
    if (acc_clr) acc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      ovf_q <= 1'b0;
      acc_q <= '0;
    end else begin
      sum_q <= sum_d;
      ovf_q <= ovf_d;
      acc_q <= acc_d;
    end
  end

  assign sum = sum_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/sum_pipe.sv
// sum_pipe: LANES-wide two-stage registered adder with valid/ready flow control.
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset; drops all in-flight items
//   acc_clr : zero every lane accumulator at the next edge
//   bus     : operand and result channels (sum_pipe_if.slave)
// s1 captures operands; s2 (one sum_lane per lane) holds the result.
// in_ready is the only combinational input-to-output path (from out_ready).
// Limits: WIDTH <= W_MAX and LANES*WIDTH <= VEC_MAX from sum_pipe_pkg.
module sum_pipe
  import sum_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LANES = 2,
  parameter int unsigned SAT   = 0
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     acc_clr,
  sum_pipe_if.slave bus
);

  localparam int unsigned VW = LANES * WIDTH;

  logic          s1_valid_q, s1_valid_d;
  logic [VW-1:0] s1_a_q, s1_a_d;
  logic [VW-1:0] s1_b_q, s1_b_d;
  mode_e         s1_mode_q, s1_mode_d;
  logic          s2_valid_q, s2_valid_d;

  logic s2_accept;
  logic s1_adv;
  logic in_rdy;
  logic accept;

  always_comb begin
    s2_accept  = !s2_valid_q || bus.out_ready;
    s1_adv     = s1_valid_q && s2_accept;
    in_rdy     = !rst && (!s1_valid_q || s1_adv);
    accept     = bus.in_valid && in_rdy;

    // Accept and advance in the same cycle leaves s1 full with the new item.
    s1_valid_d = accept || (s1_valid_q && !s1_adv);
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_mode_d  = s1_mode_q;
    if (accept) begin
      s1_a_d    = bus.in_a;
      s1_b_d    = bus.in_b;
      s1_mode_d = mode_e'(bus.in_mode);
    end

    s2_valid_d = s1_adv || (s2_valid_q && !bus.out_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_mode_q  <= MODE_ADD;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_mode_q  <= s1_mode_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  logic [WIDTH-1:0] lane_sum [LANES];
  logic             lane_ovf [LANES];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [WIDTH-1:0] a_l;
    logic [WIDTH-1:0] b_l;

    assign a_l = WIDTH'(lane(VEC_MAX'(s1_a_q), gi, WIDTH));
    assign b_l = WIDTH'(lane(VEC_MAX'(s1_b_q), gi, WIDTH));

    sum_lane #(
      .WIDTH (WIDTH),
      .SAT   (SAT != 0)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .load    (s1_adv),
      .acc_clr (acc_clr),
      .mode    (s1_mode_q),
      .a       (a_l),
      .b       (b_l),
      .sum     (lane_sum[gi]),
      .ovf     (lane_ovf[gi])
    );
  end

  logic [VW-1:0]    out_sum_w;
  logic [LANES-1:0] out_ovf_w;

  always_comb begin
    out_sum_w = '0;
    out_ovf_w = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      out_sum_w[i*WIDTH +: WIDTH] = lane_sum[i];
      out_ovf_w[i]                = lane_ovf[i];
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_sum   = out_sum_w;
  assign bus.out_ovf   = out_ovf_w;

endmodule

// File: tb/tb_sum_pipe.sv
// tb_sum_pipe: drives a wrapping (SAT=0) and a saturating (SAT=1) sum_pipe
// with identical stimulus and scores both against a queue of expected results.
module tb_sum_pipe;

  localparam int unsigned W = 4;
  localparam int unsigned L = 2;

  logic         clk;
  logic         rst;
  logic         acc_clr;
  logic         in_valid;
  logic [W*L-1:0] in_a;
  logic [W*L-1:0] in_b;
  logic         in_mode;
  logic         out_ready;

  sum_pipe_if #(.WIDTH(W), .LANES(L)) bus0 ();
  sum_pipe_if #(.WIDTH(W), .LANES(L)) bus1 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.in_a      = in_a;
  assign bus0.in_b      = in_b;
  assign bus0.in_mode   = in_mode;
  assign bus0.out_ready = out_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.in_a      = in_a;
  assign bus1.in_b      = in_b;
  assign bus1.in_mode   = in_mode;
  assign bus1.out_ready = out_ready;

  sum_pipe #(.WIDTH(W), .LANES(L), .SAT(0)) u_dut_wrap (
    .clk(clk), .rst(rst), .acc_clr(acc_clr), .bus(bus0)
  );
  sum_pipe #(.WIDTH(W), .LANES(L), .SAT(1)) u_dut_sat (
    .clk(clk), .rst(rst), .acc_clr(acc_clr), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W*L-1:0] sum0;
    logic [L-1:0]   ovf0;
    logic [W*L-1:0] sum1;
    logic [L-1:0]   ovf1;
    int unsigned    cyc;
  } exp_t;

  exp_t        sb[$];
  int          acc0 [L];
  int          acc1 [L];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  bit          chk_lat  = 1'b0;
  bit          stream_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic clr_model();
    for (int i = 0; i < int'(L); i++) begin
      acc0[i] = 0;
      acc1[i] = 0;
    end
  endtask

  task automatic push_exp(input logic [W*L-1:0] a, input logic [W*L-1:0] b, input logic mode);
    exp_t e;
    e.sum0 = '0; e.ovf0 = '0; e.sum1 = '0; e.ovf1 = '0;
    for (int l = 0; l < int'(L); l++) begin
      int ai, bi, f0, f1, r0, r1;
      ai = int'(a[l*W +: W]);
      bi = int'(b[l*W +: W]);
      f0 = ai + bi + (mode ? acc0[l] : 0);
      f1 = ai + bi + (mode ? acc1[l] : 0);
      r0 = f0 % 16;
      r1 = (f1 > 15) ? 15 : f1;
      e.sum0[l*W +: W] = 4'(r0);
      e.sum1[l*W +: W] = 4'(r1);
      e.ovf0[l] = (f0 > 15);
      e.ovf1[l] = (f1 > 15);
      if (mode) begin
        acc0[l] = r0;
        acc1[l] = r1;
      end
    end
    e.cyc = cyc;
    sb.push_back(e);
  endtask

  // Result monitor: a transfer seen at the negedge completes at the next posedge.
  bit             prev_stall = 1'b0;
  logic [W*L-1:0] prev_sum0, prev_sum1;
  logic [L-1:0]   prev_ovf0, prev_ovf1;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_valid", 32'(bus0.out_valid), 32'd1);
        check_eq("hold_sum_wrap", 32'(bus0.out_sum), 32'(prev_sum0));
        check_eq("hold_ovf_wrap", 32'(bus0.out_ovf), 32'(prev_ovf0));
        check_eq("hold_sum_sat", 32'(bus1.out_sum), 32'(prev_sum1));
        check_eq("hold_ovf_sat", 32'(bus1.out_ovf), 32'(prev_ovf1));
      end
      if (bus0.out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("spurious_out", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("sum_wrap", 32'(bus0.out_sum), 32'(e.sum0));
          check_eq("ovf_wrap", 32'(bus0.out_ovf), 32'(e.ovf0));
          check_eq("valid_sat", 32'(bus1.out_valid), 32'd1);
          check_eq("sum_sat", 32'(bus1.out_sum), 32'(e.sum1));
          check_eq("ovf_sat", 32'(bus1.out_ovf), 32'(e.ovf1));
          if (chk_lat) check_eq("latency", cyc - e.cyc, 32'd2);
        end
      end
      prev_stall = bus0.out_valid && !out_ready;
      prev_sum0  = bus0.out_sum;
      prev_ovf0  = bus0.out_ovf;
      prev_sum1  = bus1.out_sum;
      prev_ovf1  = bus1.out_ovf;
    end
  end

  task automatic send(input logic [W*L-1:0] a, input logic [W*L-1:0] b, input logic mode);
    int n = 0;
    bit done = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_mode  = mode;
    while (!done) begin
      @(negedge clk);
      if (bus0.in_ready) begin
        push_exp(a, b, mode);
        done = 1'b1;
      end else if (++n > 100) begin
        check_eq("accept_timeout", 32'd0, 32'd1);
        done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    clr_model();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; acc_clr = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_mode = 1'b0; out_ready = 1'b1;
    clr_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", 32'(bus0.out_valid), 32'd0);
    check_eq("rst_out_sum", 32'(bus0.out_sum), 32'd0);
    check_eq("rst_out_ovf", 32'(bus0.out_ovf), 32'd0);
    check_eq("rst_in_ready", 32'(bus0.in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_in_ready", 32'(bus0.in_ready), 32'd1);
    @(posedge clk); #1;

    // Plain add with latency check: lanes (1,2) and (7,8).
    chk_lat = 1'b1;
    send({4'd7, 4'd1}, {4'd8, 4'd2}, 1'b0);
    wait_drain();
    chk_lat = 1'b0;

    // Wrap vs saturate: lane0 9+9, lane1 15+1.
    send({4'd15, 4'd9}, {4'd1, 4'd9}, 1'b0);
    wait_drain();

    // Accumulate chain back-to-back, then clear and restart.
    send({4'd0, 4'd3}, {4'd0, 4'd4}, 1'b1);
    send({4'd0, 4'd5}, {4'd0, 4'd6}, 1'b1);
    wait_drain();
    pulse_clr();
    send({4'd0, 4'd1}, {4'd0, 4'd1}, 1'b1);
    wait_drain();

    // acc_clr coincident with an accumulate item advancing (acc=5).
    pulse_clr();
    send({4'd0, 4'd2}, {4'd0, 4'd3}, 1'b1);
    send({4'd0, 4'd1}, {4'd0, 4'd1}, 1'b1);
    pulse_clr();
    send({4'd0, 4'd0}, {4'd0, 4'd0}, 1'b1);
    wait_drain();

    // Backpressure: fill both stages, then stream with a random out_ready.
    out_ready = 1'b0;
    send({4'd2, 4'd4}, {4'd3, 4'd5}, 1'b0);
    send({4'd6, 4'd8}, {4'd7, 4'd9}, 1'b0);
    @(negedge clk);
    check_eq("in_ready_full", 32'(bus0.in_ready), 32'd0);
    check_eq("in_ready_full_sat", 32'(bus1.in_ready), 32'd0);
    @(posedge clk); #1;
    stream_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 8; k++)
          send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        stream_done = 1'b1;
      end
      begin
        repeat (3) @(posedge clk);
        while (!stream_done) begin
          @(posedge clk); #1;
          if (!stream_done) out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();

    // Reset with two items in flight.
    pulse_clr();
    out_ready = 1'b0;
    send({4'd0, 4'd3}, {4'd0, 4'd3}, 1'b1);
    send({4'd1, 4'd1}, {4'd1, 4'd1}, 1'b0);
    rst = 1'b1;
    sb.delete();
    clr_model();
    @(negedge clk);
    check_eq("rst_mid_in_ready", 32'(bus0.in_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rst_mid_valid", 32'(bus0.out_valid), 32'd0);
    check_eq("rst_mid_sum", 32'(bus0.out_sum), 32'd0);
    check_eq("rst_mid_ovf", 32'(bus0.out_ovf), 32'd0);
    check_eq("rst_mid_sum_sat", 32'(bus1.out_sum), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_in_ready_after", 32'(bus0.in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    send({4'd0, 4'd1}, {4'd0, 4'd1}, 1'b1);
    wait_drain();
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
